sched_epoch_ctrl: RTL and testbench
===================================

# sched_epoch_ctrl

Sequencer for the fixed-length switch scheduler. Divides time into fixed epochs and fires one `sched_en` pulse per epoch, one cycle after snapshotting `voq_empty`. Captures the scheduler's one-cycle grant pulse (`sched_sel_en`/`sched_sel`) and tracks each ingress's in-flight packet with a down-counter. Feeds the resulting `is_busy`/`busy_voq_num` back to the scheduler and drives per-ingress dequeue enables to the ingress blocks.

## Interface
Parameters:
- `PKT_CYCLES`, 16: cycles one packet occupies an ingress→egress path; legal 1..256.
- `EPOCH_CYCLES`, 8: cycles between successive `sched_en` pulses; legal 8..256. 8 is the scheduler's minimum turnaround.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  software run control
- `voq_empty`  in  16  live VOQ empty flags, 4 per ingress
- `sched_sel_en`  in  4  grant pulse from scheduler
- `sched_sel`  in  8  granted VOQ, 2 bits per ingress
- `sched_en`  out  1  one-cycle scheduler start
- `voq_empty_snap`  out  16  registered snapshot presented to scheduler
- `is_busy`  out  4  ingress transmitting
- `busy_voq_num`  out  8  VOQ in use per busy ingress
- `xmit_en`  out  4  dequeue enable to ingress; equals `is_busy`
- `stats_clr`  in  1  clear grant counters
- `grant_cnt`  out  64  4×16-bit per-ingress grant counters, ingress i at [16i+:16]

## Operation
- Epoch counter `ep` runs 0..EPOCH_CYCLES-1 and wraps. It advances only while `enable`=1 or `ep`≠0.
- `ep`=0 with `enable`=1: `voq_empty_snap`<=`voq_empty`.
- `ep`=1: `sched_en`=1, registered, for exactly one cycle.
- `sched_en` is never asserted on any other value of `ep`.
- Deasserting `enable` mid-epoch: the current epoch finishes, then `ep` parks at 0. No new snapshot or `sched_en` occurs until `enable` returns.
- Grant capture: sampled every cycle, independent of `enable`. Ingress i, when `sched_sel_en[i]`=1:
  - Not busy, or busy with remaining count 0: set `is_busy[i]`, load `busy_voq_num[2i+:2]`<=`sched_sel[2i+:2]`, load `rem[i]`<=PKT_CYCLES-1.
  - Busy with `rem[i]`>0 (scheduler re-confirming a busy port): `rem[i]` and `busy_voq_num` unchanged.
- Countdown, per ingress with no qualifying grant this cycle:
  - `is_busy[i]` and `rem[i]`>0: decrement.
  - `is_busy[i]` and `rem[i]`=0: clear `is_busy[i]`. `busy_voq_num` holds its last value.
- Result: a packet holds `is_busy` for exactly PKT_CYCLES cycles.
- `rem` width is $clog2(PKT_CYCLES), minimum 1 bit.
- Simultaneous grant and expiry on the same ingress: the new grant wins, so `is_busy` stays 1 with no gap.

## Timing
- Reset value of every output is 0, including the snapshot, counters and `grant_cnt`. `ep` resets to 0.
- Snapshot registered at the end of `ep`=0. `sched_en` is high during `ep`=1, with the snapshot already stable.
- A grant pulse in cycle T gives `is_busy`/`xmit_en`/`busy_voq_num` high from T+1 through T+PKT_CYCLES.
- Grant to next `sched_en`: the scheduler's grant lands 6 cycles after `sched_en`, so with EPOCH_CYCLES=8 the next `sched_en` sees updated `is_busy`.
- `reset` mid-packet: all state cleared immediately. The scheduler's next grant is treated as new.

## Configuration
- `SCHED_EPOCH_STATS_EN` defined:
  - `grant_cnt[i]` increments on each grant that loads a new packet.
  - Saturates at 16'hFFFF.
  - `stats_clr` zeroes all four counters, with priority over an increment in the same cycle.
- Not defined: counters are not built, `grant_cnt` is tied to 0, `stats_clr` is ignored.

## Test plan
- Reset, `enable`=1, EPOCH_CYCLES=8 → `sched_en` pulses exactly in cycles 2, 10, 18 after reset release. `voq_empty_snap` equals `voq_empty` sampled in cycles 1, 9, 17.
- PKT_CYCLES=4, grant `sched_sel_en`=4'b0101, `sched_sel`=8'b00_11_00_10 at T → `is_busy`=4'b0101 and `busy_voq_num[1:0]`=2, `[5:4]`=3 for T+1..T+4. 0 at T+5.
- PKT_CYCLES=4, new grant on ingress 0 in the cycle its `rem`=0 → `is_busy[0]` stays 1 continuously for 4 more cycles, with the new VOQ number.
- Re-grant of busy ingress 2 with `rem`=2 → expiry time and VOQ unchanged. `grant_cnt[2]` not incremented (macro defined).
- Drop `enable` at `ep`=3 → no further `sched_en`. `ep` parks at 0 after 5 cycles, and in-flight packets still complete.
- Assert `reset` while `is_busy`=4'b1111 → all outputs 0 next edge, without waiting for the clock. With the macro defined, after 65536 grants `grant_cnt[0]`=16'hFFFF, and `stats_clr` returns it to 0.

Source files
------------

// File: rtl/sched_epoch_ctrl.sv
// sched_epoch_ctrl: epoch sequencer for the fixed-length switch scheduler.
// Snapshots voq_empty and pulses sched_en once per epoch, captures
// per-ingress grants and times each in-flight packet.
// Ports: clk, reset (async, high), enable, voq_empty[15:0],
//   sched_sel_en[3:0], sched_sel[7:0] -> sched_en, voq_empty_snap[15:0],
//   is_busy[3:0], busy_voq_num[7:0], xmit_en[3:0];
//   stats_clr -> grant_cnt[63:0] (built only with SCHED_EPOCH_STATS_EN).
module sched_epoch_ctrl #(
  parameter int PKT_CYCLES   = 16,
  parameter int EPOCH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] voq_empty,
  input  logic [3:0]  sched_sel_en,
  input  logic [7:0]  sched_sel,
  output logic        sched_en,
  output logic [15:0] voq_empty_snap,
  output logic [3:0]  is_busy,
  output logic [7:0]  busy_voq_num,
  output logic [3:0]  xmit_en,
  input  logic        stats_clr,
  output logic [63:0] grant_cnt
);

  localparam int EW = $clog2(EPOCH_CYCLES);
  localparam int RW = (PKT_CYCLES > 1) ? $clog2(PKT_CYCLES) : 1;
  localparam logic [EW-1:0] EP_LAST  = EW'(EPOCH_CYCLES - 1);
  localparam logic [RW-1:0] REM_LOAD = RW'(PKT_CYCLES - 1);

  logic [EW-1:0] ep;
  logic [RW-1:0] rem [4];
  logic [3:0]    load;

  // ep=0 is the parked/snapshot slot; leaving it starts an epoch,
  // so sched_en is registered high exactly while ep=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ep             <= '0;
      sched_en       <= 1'b0;
      voq_empty_snap <= '0;
    end else begin
      sched_en <= 1'b0;
      if (ep == '0) begin
        if (enable) begin
          voq_empty_snap <= voq_empty;
          sched_en       <= 1'b1;
          ep             <= EW'(1);
        end
      end else if (ep == EP_LAST) begin
        ep <= '0;
      end else begin
        ep <= ep + EW'(1);
      end
    end
  end

  // A grant starts a new packet unless the port is mid-packet;
  // a grant landing on the last busy cycle chains with no gap.
  always_comb begin
    load = '0;
    for (int i = 0; i < 4; i++)
      load[i] = sched_sel_en[i] & (~is_busy[i] | (rem[i] == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_busy      <= '0;
      busy_voq_num <= '0;
      for (int i = 0; i < 4; i++) rem[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          is_busy[i]          <= 1'b1;
          busy_voq_num[2*i+:2] <= sched_sel[2*i+:2];
          rem[i]              <= REM_LOAD;
        end else if (is_busy[i]) begin
          if (rem[i] != '0) rem[i] <= rem[i] - RW'(1);
          else              is_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign xmit_en = is_busy;

`ifdef SCHED_EPOCH_STATS_EN
  logic [15:0] cnt [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (load[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sched_epoch_ctrl.sv
// tb_sched_epoch_ctrl: directed bench for sched_epoch_ctrl with a
// time-based reference model checked every cycle on the falling edge.
module tb_sched_epoch_ctrl;

  localparam int PKT = 4;
  localparam int EPC = 8;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] voq_empty;
  logic [3:0]  sched_sel_en;
  logic [7:0]  sched_sel;
  logic        stats_clr;
  logic        sched_en;
  logic [15:0] voq_empty_snap;
  logic [3:0]  is_busy;
  logic [7:0]  busy_voq_num;
  logic [3:0]  xmit_en;
  logic [63:0] grant_cnt;

  logic        s_enable;
  logic [15:0] s_voq;
  logic [3:0]  s_sel_en;
  logic [7:0]  s_sel;
  logic        s_clr;
  logic        s_sched_en;
  logic [15:0] s_snap;
  logic [3:0]  s_busy;
  logic [7:0]  s_bvn;
  logic [3:0]  s_xmit;
  logic [63:0] s_grant_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  sched_epoch_ctrl #(.PKT_CYCLES(PKT), .EPOCH_CYCLES(EPC)) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .voq_empty(voq_empty), .sched_sel_en(sched_sel_en),
    .sched_sel(sched_sel), .sched_en(sched_en),
    .voq_empty_snap(voq_empty_snap), .is_busy(is_busy),
    .busy_voq_num(busy_voq_num), .xmit_en(xmit_en),
    .stats_clr(stats_clr), .grant_cnt(grant_cnt)
  );

  // One-cycle packets: every grant loads, used for counter saturation.
  sched_epoch_ctrl #(.PKT_CYCLES(1), .EPOCH_CYCLES(8)) u_sat (
    .clk(clk), .reset(reset), .enable(s_enable),
    .voq_empty(s_voq), .sched_sel_en(s_sel_en),
    .sched_sel(s_sel), .sched_en(s_sched_en),
    .voq_empty_snap(s_snap), .is_busy(s_busy),
    .busy_voq_num(s_bvn), .xmit_en(s_xmit),
    .stats_clr(s_clr), .grant_cnt(s_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: m_cyc counts clock edges since reset. A packet
  // granted at edge n occupies cycles n+1..n+PKT (m_until = last one).
  int          m_cyc;
  int          m_until [4];
  logic [1:0]  m_voq [4];
  int          m_cnt [4];
  bit          m_idle;
  int          m_start;
  logic [15:0] m_snap;
  bit          m_sen;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc   = 0;
      m_idle  = 1;
      m_start = 0;
      m_snap  = '0;
      m_sen   = 0;
      for (int i = 0; i < 4; i++) begin
        m_until[i] = -1;
        m_voq[i]   = '0;
        m_cnt[i]   = 0;
      end
    end else begin
      m_sen = 0;
      if (m_idle) begin
        if (enable) begin
          m_idle  = 0;
          m_start = m_cyc;
          m_snap  = voq_empty;
          m_sen   = 1;
        end
      end else if (m_cyc - m_start == EPC - 1) begin
        m_idle = 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (sched_sel_en[i] && m_cyc >= m_until[i]) begin
          m_until[i] = m_cyc + PKT;
          m_voq[i]   = sched_sel[2*i+:2];
`ifdef SCHED_EPOCH_STATS_EN
          if (m_cnt[i] < 65535) m_cnt[i]++;
`endif
        end
      end
`ifdef SCHED_EPOCH_STATS_EN
      if (stats_clr)
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
      m_cyc++;
    end
  end

  logic [3:0]  e_busy;
  logic [7:0]  e_voq;
  logic [63:0] e_cnt;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      e_busy[i]       = (m_cyc <= m_until[i]);
      e_voq[2*i+:2]   = m_voq[i];
      e_cnt[16*i+:16] = 16'(m_cnt[i]);
    end
    check("m_sched_en", 64'(sched_en), 64'(m_sen));
    check("m_snap", 64'(voq_empty_snap), 64'(m_snap));
    check("m_is_busy", 64'(is_busy), 64'(e_busy));
    check("m_xmit_en", 64'(xmit_en), 64'(e_busy));
    check("m_busy_voq", 64'(busy_voq_num), 64'(e_voq));
    check("m_grant_cnt", grant_cnt, e_cnt);
  end

`ifdef SCHED_EPOCH_STATS_EN
  localparam int EXP_G2 = 2;
`else
  localparam int EXP_G2 = 0;
`endif

  int n_sen;
  int sen_at [3];
  int quiet;
  bit found;

  initial begin
    reset = 1; enable = 0; voq_empty = '0;
    sched_sel_en = '0; sched_sel = '0; stats_clr = 0;
    s_enable = 0; s_voq = '0; s_sel_en = '0; s_sel = '0; s_clr = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(is_busy), 64'd0);
    check("rst_sched_en", 64'(sched_en), 64'd0);
    check("rst_cnt", grant_cnt, 64'd0);

    // Epoch cadence: cycle 1 is the first cycle after reset release.
    reset = 0; enable = 1; voq_empty = 16'hA501;
    n_sen = 0;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (sched_en) begin
        if (n_sen < 3) sen_at[n_sen] = c;
        n_sen++;
      end
      if (c == 3)  check("snap_c1", 64'(voq_empty_snap), 64'hA501);
      if (c == 11) check("snap_c9", 64'(voq_empty_snap), 64'hA509);
      if (c == 19) check("snap_c17", 64'(voq_empty_snap), 64'hA511);
      voq_empty = 16'(32'hA500 + c);
    end
    check("sen_count", 64'(n_sen), 64'd3);
    check("sen_first", 64'(sen_at[0]), 64'd2);
    check("sen_second", 64'(sen_at[1]), 64'd10);
    check("sen_third", 64'(sen_at[2]), 64'd18);

    // Two ingresses granted together.
    sched_sel_en = 4'b0101; sched_sel = 8'b00_11_00_10;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      sched_sel_en = '0;
      if (k <= 4) begin
        check("pair_busy", 64'(is_busy), 64'b0101);
        check("pair_voq0", 64'(busy_voq_num[1:0]), 64'd2);
        check("pair_voq2", 64'(busy_voq_num[5:4]), 64'd3);
      end else begin
        check("pair_done", 64'(is_busy), 64'd0);
      end
    end

    // Back-to-back packets on ingress 0, second grant at rem=0.
    sched_sel_en = 4'b0001; sched_sel = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sched_sel_en = '0;
      if (k <= 4) begin
        check("chain_busy_a", 64'(is_busy[0]), 64'd1);
        check("chain_voq_a", 64'(busy_voq_num[1:0]), 64'd0);
      end else if (k <= 8) begin
        check("chain_busy_b", 64'(is_busy[0]), 64'd1);
        check("chain_voq_b", 64'(busy_voq_num[1:0]), 64'd1);
      end else begin
        check("chain_done", 64'(is_busy[0]), 64'd0);
      end
      if (k == 4) begin
        sched_sel_en = 4'b0001; sched_sel = 8'h01;
      end
    end

    // Re-grant of busy ingress 2 while rem=2 is ignored.
    sched_sel_en = 4'b0100; sched_sel = 8'b00_01_00_00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      sched_sel_en = '0;
      if (k <= 4) begin
        check("regrant_busy", 64'(is_busy[2]), 64'd1);
        check("regrant_voq", 64'(busy_voq_num[5:4]), 64'd1);
      end else begin
        check("regrant_done", 64'(is_busy[2]), 64'd0);
      end
      if (k == 2) begin
        sched_sel_en = 4'b0100; sched_sel = 8'b00_10_00_00;
      end
    end
    check("regrant_cnt2", 64'(grant_cnt[47:32]), 64'(EXP_G2));

    // Clear wins over a same-cycle loading grant.
    stats_clr = 1; sched_sel_en = 4'b0010; sched_sel = 8'b0000_1100;
    @(negedge clk);
    stats_clr = 0; sched_sel_en = '0;
    check("clr_all", grant_cnt, 64'd0);
    repeat (PKT + 1) @(negedge clk);

    // Drop enable at ep=3 with a packet in flight.
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (sched_en) found = 1;
    end
    check("ep1_found", 64'(found), 64'd1);
    sched_sel_en = 4'b1000; sched_sel = 8'b10_00_00_00;
    @(negedge clk);
    sched_sel_en = '0;
    @(negedge clk);
    enable = 0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (sched_en) quiet++;
    end
    check("disabled_sen", 64'(quiet), 64'd0);
    enable = 1;
    @(negedge clk);
    check("reenable_sen", 64'(sched_en), 64'd1);

    // Asynchronous reset with all four ingresses busy.
    sched_sel_en = 4'b1111; sched_sel = 8'hE4;
    @(negedge clk);
    sched_sel_en = '0;
    @(negedge clk);
    check("all_busy", 64'(is_busy), 64'hF);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("arst_busy", 64'(is_busy), 64'd0);
    check("arst_xmit", 64'(xmit_en), 64'd0);
    check("arst_voq", 64'(busy_voq_num), 64'd0);
    check("arst_snap", 64'(voq_empty_snap), 64'd0);
    check("arst_sen", 64'(sched_en), 64'd0);
    check("arst_cnt", grant_cnt, 64'd0);
    @(negedge clk);
    reset = 0;
    sched_sel_en = 4'b0001; sched_sel = 8'h03;
    @(negedge clk);
    sched_sel_en = '0;
    check("post_rst_grant", 64'(is_busy), 64'd1);
    repeat (PKT + 2) @(negedge clk);

`ifdef SCHED_EPOCH_STATS_EN
    // Saturation on the one-cycle-packet instance.
    s_sel_en = 4'b0001;
    repeat (65534) @(negedge clk);
    check("sat_fffe", 64'(s_grant_cnt[15:0]), 64'hFFFE);
    @(negedge clk);
    check("sat_ffff", 64'(s_grant_cnt[15:0]), 64'hFFFF);
    repeat (5) @(negedge clk);
    check("sat_hold", 64'(s_grant_cnt[15:0]), 64'hFFFF);
    s_clr = 1;
    @(negedge clk);
    s_clr = 0; s_sel_en = '0;
    check("sat_clr", s_grant_cnt, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule
